// File: rtl/regfile_multiport.sv
// rtl/regfile_multiport.sv - parametrised multi-read-port register file with optional bypass and registered reads
module regfile_multiport #(
    parameter int WIDTH   = 32,
    parameter int ADDR_W  = 5,
    parameter int DEPTH   = 32,
    parameter int NUM_RD  = 2,
    parameter int ZERO_R0 = 1,
    parameter int BYPASS  = 1,
    parameter int RD_REG  = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        wa,
    input  logic [WIDTH-1:0]         wd,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] ra,
    output logic [NUM_RD*WIDTH-1:0]  rd,
    output logic [NUM_RD-1:0]        rd_valid
);

    logic [WIDTH-1:0]             mem_q [DEPTH];
    logic [NUM_RD-1:0][WIDTH-1:0] rd_d;

    // Storage: reset clears every register; writes to unimplemented addresses or a hardwired r0 are dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wa == ADDR_W'(i) && !(ZERO_R0 != 0 && i == 0)) begin
                    mem_q[i] <= wd;
                end
            end
        end
    end

    // Effective read value per port: out-of-range and r0 force zero ahead of bypass, then bypass, then storage
    always_comb begin
        rd_d = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            logic [ADDR_W-1:0] ra_k;
            logic              in_range;
            ra_k     = ra[k*ADDR_W +: ADDR_W];
            in_range = ({1'b0, ra_k} < (ADDR_W+1)'(DEPTH));
            rd_d[k]  = '0;
            // decoder-style mux never matches an unimplemented address, so those read as zero
            for (int i = 0; i < DEPTH; i++) begin
                if (ra_k == ADDR_W'(i)) begin
                    rd_d[k] = mem_q[i];
                end
            end
            if (!in_range || (ZERO_R0 != 0 && ra_k == '0)) begin
                rd_d[k] = '0;
            end else if (BYPASS != 0 && we && wa == ra_k) begin
                rd_d[k] = wd;
            end
        end
    end

    generate
        if (RD_REG != 0) begin : g_rdreg
            logic [NUM_RD-1:0][WIDTH-1:0] rd_q;
            logic [NUM_RD-1:0]            rd_valid_q;

            // Read stage: capture on enable, hold data otherwise; valid tracks the enable one cycle later
            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_q       <= '0;
                    rd_valid_q <= '0;
                end else begin
                    for (int k = 0; k < NUM_RD; k++) begin
                        if (rd_en[k]) begin
                            rd_q[k] <= rd_d[k];
                        end
                    end
                    rd_valid_q <= rd_en;
                end
            end

            assign rd       = rd_q;
            assign rd_valid = rd_valid_q;
        end else begin : g_comb
            logic unused_rd_en;
            assign unused_rd_en = ^rd_en;
            assign rd           = rd_d;
            assign rd_valid     = '1;
        end
    endgenerate

endmodule

// File: tb/tb_regfile_multiport.sv
// tb/tb_regfile_multiport.sv - directed table, corner sequences and random stress against a reference model
module tb_regfile_multiport;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [3:0]  rd_en;
    logic [19:0] ra;

    logic [63:0]  rd_def;
    logic [1:0]   rv_def;
    logic [127:0] rd_s [8];
    logic [3:0]   rv_s [8];

    int n_cmp = 0;
    int n_err = 0;
    bit en_chk = 1'b0;

    regfile_multiport #(
        .WIDTH(32), .ADDR_W(5), .DEPTH(32), .NUM_RD(2),
        .ZERO_R0(1), .BYPASS(1), .RD_REG(0)
    ) u_def (
        .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd),
        .rd_en(rd_en[1:0]), .ra(ra[9:0]), .rd(rd_def), .rd_valid(rv_def)
    );

    // config g: bit0 = BYPASS, bit1 = RD_REG, bit2 = ZERO_R0 (and DEPTH=24)
    generate
        for (genvar g = 0; g < 8; g++) begin : g_cfg
            regfile_multiport #(
                .WIDTH(32), .ADDR_W(5), .DEPTH((g >= 4) ? 24 : 32), .NUM_RD(4),
                .ZERO_R0((g >= 4) ? 1 : 0), .BYPASS(g % 2), .RD_REG((g / 2) % 2)
            ) u_dut (
                .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd),
                .rd_en(rd_en), .ra(ra), .rd(rd_s[g]), .rd_valid(rv_s[g])
            );
        end
    endgenerate

    // reference model state
    logic [31:0] mem [8][32];
    logic [31:0] erd [8][4];
    logic [3:0]  ev  [8];

    function automatic bit byp(int c); return (c % 2) == 1; endfunction
    function automatic bit rr(int c);  return ((c / 2) % 2) == 1; endfunction
    function automatic bit zr(int c);  return c >= 4; endfunction
    function automatic int dep(int c); return (c >= 4) ? 24 : 32; endfunction

    function automatic logic [31:0] m_eff(int c, int a);
        if (a >= dep(c)) return 32'h0;
        if (zr(c) && a == 0) return 32'h0;
        if (byp(c) && we === 1'b1 && int'(wa) == a) return wd;
        return mem[c][a];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input bit r, input bit w, input logic [4:0] a, input logic [31:0] d,
                         input logic [19:0] ras, input logic [3:0] en);
        rst = r; we = w; wa = a; wd = d; ra = ras; rd_en = en;
        #1;
        if (en_chk) begin
            for (int c = 0; c < 8; c++) begin
                if (!rr(c)) begin
                    for (int k = 0; k < 4; k++)
                        chk($sformatf("comb_rd c%0d p%0d", c, k), rd_s[c][k*32 +: 32], m_eff(c, int'(ras[k*5 +: 5])));
                    chk($sformatf("comb_valid c%0d", c), {28'd0, rv_s[c]}, 32'hF);
                end
            end
        end
        for (int c = 0; c < 8; c++) begin
            if (rr(c)) begin
                for (int k = 0; k < 4; k++) begin
                    if (r) begin
                        erd[c][k] = 32'h0;
                        ev[c][k]  = 1'b0;
                    end else begin
                        if (en[k]) erd[c][k] = m_eff(c, int'(ras[k*5 +: 5]));
                        ev[c][k] = en[k];
                    end
                end
            end
        end
        for (int c = 0; c < 8; c++) begin
            if (r) begin
                for (int i = 0; i < 32; i++) mem[c][i] = 32'h0;
            end else if (w && int'(a) < dep(c) && !(zr(c) && a == 5'd0)) begin
                mem[c][a] = d;
            end
        end
    endtask

    task automatic clock();
        @(posedge clk);
        #1;
        if (en_chk) begin
            for (int c = 0; c < 8; c++) begin
                if (rr(c)) begin
                    for (int k = 0; k < 4; k++)
                        chk($sformatf("reg_rd c%0d p%0d", c, k), rd_s[c][k*32 +: 32], erd[c][k]);
                    chk($sformatf("reg_valid c%0d", c), {28'd0, rv_s[c]}, {28'd0, ev[c]});
                end
            end
        end
    endtask

    typedef struct {
        bit          r;
        bit          w;
        logic [4:0]  a;
        logic [31:0] d;
        logic [4:0]  r0;
        logic [4:0]  r1;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;

    vec_t tv [12];

    initial begin
        logic [19:0] ras;
        bit          r, w;
        logic [4:0]  a;

        tv[0]  = '{1'b1, 1'b0, 5'd0, 32'h0,        5'd0, 5'd0,  32'h0,        32'h0};
        tv[1]  = '{1'b0, 1'b0, 5'd0, 32'h0,        5'd0, 5'd31, 32'h0,        32'h0};
        tv[2]  = '{1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd6,  32'hDEADBEEF, 32'h0};
        tv[3]  = '{1'b0, 1'b0, 5'd0, 32'h0,        5'd5, 5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
        tv[4]  = '{1'b0, 1'b1, 5'd0, 32'h1234,     5'd0, 5'd5,  32'h0,        32'hDEADBEEF};
        tv[5]  = '{1'b0, 1'b0, 5'd0, 32'h0,        5'd0, 5'd0,  32'h0,        32'h0};
        tv[6]  = '{1'b0, 1'b1, 5'd7, 32'h11,       5'd7, 5'd7,  32'h11,       32'h11};
        tv[7]  = '{1'b0, 1'b1, 5'd7, 32'h22,       5'd7, 5'd5,  32'h22,       32'hDEADBEEF};
        tv[8]  = '{1'b0, 1'b0, 5'd0, 32'h0,        5'd7, 5'd7,  32'h22,       32'h22};
        tv[9]  = '{1'b1, 1'b1, 5'd4, 32'h99,       5'd4, 5'd5,  32'h99,       32'hDEADBEEF};
        tv[10] = '{1'b0, 1'b0, 5'd0, 32'h0,        5'd4, 5'd5,  32'h0,        32'h0};
        tv[11] = '{1'b0, 1'b0, 5'd0, 32'h0,        5'd7, 5'd5,  32'h0,        32'h0};

        // directed table on the default configuration
        for (int i = 0; i < 12; i++) begin
            drive(tv[i].r, tv[i].w, tv[i].a, tv[i].d, {10'd0, tv[i].r1, tv[i].r0}, 4'hF);
            if (en_chk) begin
                chk($sformatf("def_rd0 v%0d", i), rd_def[31:0], tv[i].e0);
                chk($sformatf("def_rd1 v%0d", i), rd_def[63:32], tv[i].e1);
                chk($sformatf("def_valid v%0d", i), {30'd0, rv_def}, 32'h3);
            end
            clock();
            en_chk = 1'b1;
        end

        // bypass off vs on, combinational read
        drive(1'b0, 1'b1, 5'd7, 32'h11, {15'd0, 5'd7}, 4'hF); clock();
        drive(1'b0, 1'b1, 5'd7, 32'h22, {15'd0, 5'd7}, 4'hF);
        chk("nobyp_same_cycle", rd_s[0][31:0], 32'h11);
        chk("byp_same_cycle", rd_s[1][31:0], 32'h22);
        clock();
        drive(1'b0, 1'b0, 5'd0, 32'h0, {15'd0, 5'd7}, 4'hF);
        chk("nobyp_after_edge", rd_s[0][31:0], 32'h22);
        clock();

        // registered read: latency, hold on disable, pre-write value, reset mid-read
        drive(1'b0, 1'b1, 5'd3, 32'hA5A5, 20'd0, 4'h0); clock();
        drive(1'b0, 1'b0, 5'd0, 32'h0, {15'd0, 5'd3}, 4'b0001); clock();
        chk("regrd_data", rd_s[2][31:0], 32'hA5A5);
        chk("regrd_valid", {28'd0, rv_s[2]}, 32'h1);
        drive(1'b0, 1'b1, 5'd3, 32'h5A5A, {15'd0, 5'd3}, 4'h0); clock();
        chk("regrd_hold", rd_s[2][31:0], 32'hA5A5);
        chk("regrd_valid_drop", {28'd0, rv_s[2]}, 32'h0);
        drive(1'b0, 1'b1, 5'd3, 32'h7777, {15'd0, 5'd3}, 4'b0001); clock();
        chk("regrd_nobyp_prewrite", rd_s[2][31:0], 32'h5A5A);
        chk("regrd_byp", rd_s[3][31:0], 32'h7777);
        drive(1'b1, 1'b0, 5'd0, 32'h0, {15'd0, 5'd3}, 4'hF); clock();
        chk("regrd_rst_data", rd_s[2][31:0], 32'h0);
        chk("regrd_rst_valid", {28'd0, rv_s[2]}, 32'h0);

        // DEPTH=24: out-of-range write/read, reset beats a same-cycle write
        drive(1'b0, 1'b1, 5'd30, 32'hFF, {15'd0, 5'd30}, 4'hF);
        chk("oob_same_cycle", rd_s[4][31:0], 32'h0);
        chk("oob_beats_bypass", rd_s[5][31:0], 32'h0);
        clock();
        drive(1'b0, 1'b0, 5'd0, 32'h0, {15'd0, 5'd30}, 4'hF);
        chk("oob_after", rd_s[4][31:0], 32'h0);
        clock();
        drive(1'b1, 1'b1, 5'd4, 32'h99, 20'd0, 4'hF); clock();
        drive(1'b0, 1'b0, 5'd0, 32'h0, {15'd0, 5'd4}, 4'hF);
        chk("rst_drops_write", rd_s[4][31:0], 32'h0);
        clock();

        // random stress on all eight configurations
        for (int n = 0; n < 10000; n++) begin
            r = ($urandom_range(0, 499) == 0);
            w = $urandom_range(0, 1);
            a = 5'($urandom_range(0, 31));
            for (int k = 0; k < 4; k++)
                ras[k*5 +: 5] = ($urandom_range(0, 3) == 0) ? a : 5'($urandom_range(0, 31));
            drive(r, w, a, $urandom, ras, 4'($urandom_range(0, 15)));
            clock();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
